// File: rtl/gf_poly_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : gf_poly_mul_seq
// Brief    : Sequential polynomial multiplier over GF(2^SIZE), one term/cycle,
//            with optional accumulate onto the held product.
// Revision : 1.0 - initial release
// ============================================================================
module gf_poly_mul_seq #(
    parameter int            SIZE = 8,
    parameter logic [SIZE:0] PRIM = 9'h11D,
    parameter int            NP   = 2,
    parameter int            NQ   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     acc,
    input  logic [(NP+1)*SIZE-1:0]   flat_p,
    input  logic [(NQ+1)*SIZE-1:0]   flat_q,
    output logic [(NP+NQ+1)*SIZE-1:0] flat_z,
    output logic                     busy,
    output logic                     done
);

    localparam int NZ = NP + NQ;
    localparam int IW = (NP > 0) ? $clog2(NP + 1) : 1;
    localparam int JW = (NQ > 0) ? $clog2(NQ + 1) : 1;
    localparam logic [IW-1:0] c_i_last = IW'(NP);
    localparam logic [JW-1:0] c_j_last = JW'(NQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_load;
    logic                     w_step;
    logic                     w_last;

    logic [(NP+1)*SIZE-1:0]   r_p;
    logic [(NQ+1)*SIZE-1:0]   r_q;
    logic                     r_acc_mode;
    logic [(NZ+1)*SIZE-1:0]   r_acc_z;
    logic [IW-1:0]            r_i;
    logic [JW-1:0]            r_j;

    logic [SIZE-1:0]          w_pi;
    logic [SIZE-1:0]          w_qj;
    logic [SIZE-1:0]          w_term;
    logic [(NZ+1)*SIZE-1:0]   w_acc_next;

    // Shift-and-add multiply; the running multiplicand is reduced every step
    // so no intermediate ever exceeds SIZE bits.
    function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                               input logic [SIZE-1:0] b);
        logic [SIZE-1:0] r;
        logic [SIZE-1:0] x;
        r = '0;
        x = a;
        for (int n = 0; n < SIZE; n++) begin
            if (b[n]) r = r ^ x;
            x = x[SIZE-1] ? ((x << 1) ^ PRIM[SIZE-1:0]) : (x << 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if ((r_i == c_i_last) && (r_j == c_j_last)) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pi = '0;
        for (int k = 0; k <= NP; k++) begin
            if (r_i == IW'(k)) w_pi = r_p[k*SIZE +: SIZE];
        end
        w_qj = '0;
        for (int k = 0; k <= NQ; k++) begin
            if (r_j == JW'(k)) w_qj = r_q[k*SIZE +: SIZE];
        end
        w_term     = gf_mul(w_pi, w_qj);
        w_acc_next = r_acc_z;
        for (int k = 0; k <= NZ; k++) begin
            if ((int'(r_i) + int'(r_j)) == k)
                w_acc_next[k*SIZE +: SIZE] = r_acc_z[k*SIZE +: SIZE] ^ w_term;
        end
    end

    // flat_z is only written on the final term so it holds through CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_p        <= '0;
            r_q        <= '0;
            r_acc_mode <= 1'b0;
            r_acc_z    <= '0;
            r_i        <= '0;
            r_j        <= '0;
            flat_z     <= '0;
        end else if (w_load) begin
            r_p        <= flat_p;
            r_q        <= flat_q;
            r_acc_mode <= acc;
            r_acc_z    <= '0;
            r_i        <= '0;
            r_j        <= '0;
        end else if (w_step) begin
            r_acc_z <= w_acc_next;
            if (w_last) begin
                r_i    <= '0;
                r_j    <= '0;
                flat_z <= r_acc_mode ? (flat_z ^ w_acc_next) : w_acc_next;
            end else if (r_j == c_j_last) begin
                r_j <= '0;
                r_i <= r_i + IW'(1);
            end else begin
                r_j <= r_j + JW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_poly_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_poly_mul_seq
// Brief    : Directed and randomised checks of gf_poly_mul_seq against a
//            polynomial-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_poly_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, acc;
    logic [23:0] p, q;
    logic [39:0] z;
    logic        busy, done;

    logic        s0_start, s0_acc, s0_busy, s0_done;
    logic [7:0]  s0_p, s0_q, s0_z;
    logic        s1_start, s1_acc, s1_busy, s1_done;
    logic [39:0] s1_p;
    logic [31:0] s1_q;
    logic [63:0] s1_z;

    gf_poly_mul_seq #(.SIZE(8), .PRIM(9'h11D), .NP(2), .NQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .acc(acc),
        .flat_p(p), .flat_q(q), .flat_z(z), .busy(busy), .done(done));

    gf_poly_mul_seq #(.SIZE(8), .PRIM(9'h11D), .NP(0), .NQ(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(s0_start), .acc(s0_acc),
        .flat_p(s0_p), .flat_q(s0_q), .flat_z(s0_z), .busy(s0_busy), .done(s0_done));

    gf_poly_mul_seq #(.SIZE(8), .PRIM(9'h11D), .NP(4), .NQ(3)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .acc(s1_acc),
        .flat_p(s1_p), .flat_q(s1_q), .flat_z(s1_z), .busy(s1_busy), .done(s1_done));

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    // Full carry-less product, then long division by the field polynomial.
    function automatic logic [7:0] ref_gfm(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] cl;
        cl = 16'h0;
        for (int b = 0; b < 8; b++)
            if (y[b]) cl = cl ^ (16'(x) << b);
        for (int b = 14; b >= 8; b--)
            if (cl[b]) cl = cl ^ (16'h011D << (b - 8));
        return cl[7:0];
    endfunction

    function automatic logic [79:0] ref_pmul(input logic [39:0] pv, input logic [39:0] qv,
                                             input int np, input int nq);
        logic [79:0] r;
        logic [79:0] t;
        r = '0;
        for (int i = 0; i <= np; i++)
            for (int j = 0; j <= nq; j++) begin
                t = {72'b0, ref_gfm(pv[8*i +: 8], qv[8*j +: 8])};
                r = r ^ (t << (8 * (i + j)));
            end
        return r;
    endfunction

    // Cycle model of the default-parameter instance: countdown of remaining
    // terms, a done flag, and the held product.
    int          m_left;
    logic        m_done, m_accm;
    logic [39:0] m_z, m_res;
    logic [79:0] ref_main;
    logic        cmp_en;

    always_comb ref_main = ref_pmul({16'b0, p}, {16'b0, q}, 2, 2);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_z    <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_z    <= m_accm ? (m_z ^ m_res) : m_res;
                m_done <= 1'b1;
            end
        end else if (start) begin
            m_res  <= ref_main[39:0];
            m_accm <= acc;
            m_left <= 9;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", busy, m_left > 0);
            chk("done", done, m_done);
            chk("flat_z", z, m_z);
        end
    end

    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_main(input logic [23:0] pv, input logic [23:0] qv, input logic a,
                            input logic [39:0] exp_z, input string nm);
        int lat;
        @(posedge clk); #2;
        start = 1'b1; p = pv; q = qv; acc = a;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        chk({nm, " latency"}, lat, 9);
        chk({nm, " flat_z"}, z, exp_z);
    endtask

    task automatic sweep_op(input int sel, input logic [39:0] pv, input logic [31:0] qv,
                            input logic a, output int lat, output logic [79:0] zz,
                            output logic bsy);
        @(posedge clk); #2;
        if (sel == 0) begin
            s0_start = 1'b1; s0_acc = a; s0_p = pv[7:0]; s0_q = qv[7:0];
        end else begin
            s1_start = 1'b1; s1_acc = a; s1_p = pv; s1_q = qv;
        end
        @(posedge clk); #2;
        s0_start = 1'b0;
        s1_start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); #1;
            if ((sel == 0) ? s0_done : s1_done) begin
                lat = c;
                break;
            end
        end
        zz  = (sel == 0) ? {72'b0, s0_z} : {16'b0, s1_z};
        bsy = (sel == 0) ? s0_busy : s1_busy;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, ndone;
        logic [79:0] zz, r;
        logic [39:0] pv;
        logic [31:0] qv;
        logic        a, bsy;
        logic [7:0]  e0;
        logic [63:0] e1;

        rst_n = 1'b0; start = 1'b0; acc = 1'b0; p = '0; q = '0;
        s0_start = 1'b0; s0_acc = 1'b0; s0_p = '0; s0_q = '0;
        s1_start = 1'b0; s1_acc = 1'b0; s1_p = '0; s1_q = '0;
        cmp_en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1'b1;
        chk("reset flat_z", z, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        rst_n = 1'b1;

        chk("model 80*02", ref_gfm(8'h80, 8'h02), 8'h1D);
        chk("model 8E*02", ref_gfm(8'h8E, 8'h02), 8'h01);
        chk("model case1", ref_pmul(40'h040105, 40'h020003, 2, 2), 80'h080206030F);

        run_main(24'h040105, 24'h020003, 1'b0, 40'h080206030F, "case1");
        run_main(24'h000080, 24'h000002, 1'b0, 40'h000000001D, "case2");
        run_main(24'h040105, 24'h020003, 1'b0, 40'h080206030F, "case3 base");
        run_main(24'h040105, 24'h020003, 1'b1, 40'h0000000000, "case3 acc1");
        run_main(24'h040105, 24'h020003, 1'b1, 40'h080206030F, "case3 acc2");

        // start held high with altered operands through CALC and DONE
        @(posedge clk); #2;
        start = 1'b1; p = 24'h040105; q = 24'h020003; acc = 1'b0;
        @(posedge clk); #2;
        p = 24'hFFFFFF; q = 24'h123456; acc = 1'b1;
        wait_done(lat);
        start = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("case4 latency", lat, 9);
        chk("case4 flat_z", z, 40'h080206030F);
        chk("case4 extra done", ndone, 0);

        // reset during the fourth CALC cycle
        @(posedge clk); #2;
        start = 1'b1; p = 24'h040105; q = 24'h020003; acc = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("case5 flat_z", z, 0);
        chk("case5 busy", busy, 0);
        chk("case5 done", done, 0);
        #1;
        rst_n = 1'b1; start = 1'b1; p = 24'h000080; q = 24'h000002; acc = 1'b0;
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(lat);
        chk("case5 rerun latency", lat, 9);
        chk("case5 rerun flat_z", z, 40'h000000001D);

        e0 = '0;
        for (int n = 0; n < 1000; n++) begin
            pv = 40'({$urandom(), $urandom()});
            qv = $urandom();
            if (n % 5 == 0) pv[7:0] = 8'h00;
            a = 1'($urandom_range(0, 1));
            sweep_op(0, pv, qv, a, lat, zz, bsy);
            r  = ref_pmul(pv, {8'b0, qv}, 0, 0);
            e0 = a ? (e0 ^ r[7:0]) : r[7:0];
            chk("s0 latency", lat, 1);
            chk("s0 flat_z", zz, {72'b0, e0});
            chk("s0 busy at done", bsy, 0);
        end

        e1 = '0;
        for (int n = 0; n < 1000; n++) begin
            pv = 40'({$urandom(), $urandom()});
            qv = $urandom();
            if (n % 4 == 0) pv = pv & 40'hFF00FF00FF;
            if (n % 7 == 0) qv = qv & 32'h00FF00FF;
            a = 1'($urandom_range(0, 1));
            sweep_op(1, pv, qv, a, lat, zz, bsy);
            r  = ref_pmul(pv, {8'b0, qv}, 4, 3);
            e1 = a ? (e1 ^ r[63:0]) : r[63:0];
            chk("s1 latency", lat, 20);
            chk("s1 flat_z", zz, {16'b0, e1});
            chk("s1 busy at done", bsy, 0);
        end

        @(posedge clk); #2;
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf_poly_mul_seq.md
GF_POLY_MUL_SEQ -- requirements
Module: gf_poly_mul_seq

Interface
REQ-001 Parameter SIZE, default 8: symbol width in bits; the field is GF(2^SIZE).
REQ-002 Parameter PRIM, default 9'h11D: primitive polynomial, SIZE+1 bits, MSB set.
REQ-003 Parameter NP, default 2: degree of operand p.
REQ-004 Parameter NQ, default 2: degree of operand q.
REQ-005 Derived parameter NZ = NP+NQ: degree of the product; NT = (NP+1)*(NQ+1): number of product terms.
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 Port start, input, 1 bit: request to begin a multiply.
REQ-009 Port acc, input, 1 bit: sampled with start; 1 adds the new product onto the held flat_z, 0 replaces it.
REQ-010 Port flat_p, input, (NP+1)*SIZE bits: coefficient i is at bits [i*SIZE +: SIZE], constant term in the LSBs.
REQ-011 Port flat_q, input, (NQ+1)*SIZE bits: same packing as flat_p.
REQ-012 Port flat_z, output, (NZ+1)*SIZE bits: registered product, same packing.
REQ-013 Port busy, output, 1 bit: high while the block is in CALC.
REQ-014 Port done, output, 1 bit: one-cycle pulse marking flat_z as updated.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-016 In IDLE, with start=1 at an edge, the block SHALL latch flat_p, flat_q and acc, zero the internal accumulator and i/j term counters, and enter CALC.
REQ-017 start SHALL be ignored in CALC and DONE; operands SHALL NOT be re-sampled after acceptance.
REQ-018 Each CALC cycle SHALL compute one term, acc_z[i+j] ^= gfmul(p[i], q[j]), with j incrementing fastest, from (0,0) to (NP,NQ).
REQ-019 gfmul SHALL be carry-less multiplication reduced modulo PRIM; the result SHALL be exactly SIZE bits; addition SHALL be bitwise XOR.
REQ-020 The edge that adds term (NP,NQ) SHALL load flat_z with the accumulator when latched acc=0, or with flat_z XOR accumulator when acc=1, and SHALL enter DONE.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high for exactly the cycle after edge k+NT, and flat_z SHALL be valid from that point.
REQ-022 busy SHALL be high from edge k until edge k+NT, and low in IDLE and DONE.
REQ-023 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-024 flat_z SHALL change only at the REQ-020 edge or at reset, and SHALL hold its value otherwise, including during CALC.
REQ-025 Zero coefficients SHALL follow the normal term sequence with no early termination; latency SHALL be data-independent.
REQ-026 With NP=0 or NQ=0 the block SHALL work unchanged; NT=1 gives done one cycle after acceptance.

Reset
REQ-027 When rst_n=0 at an edge, the block SHALL set state to IDLE and clear busy, done, flat_z, the accumulator, the counters and the latched operands, regardless of current state.
REQ-028 Reset mid-CALC SHALL abort the operation with no done pulse; a start in the first cycle after rst_n returns high SHALL be accepted normally.

Verification
REQ-029 Case 1, basic multiply: flat_p=24'h040105, flat_q=24'h020003, acc=0, start pulse -> done 9 cycles after acceptance, flat_z=40'h080206030F, busy high for 9 cycles.
REQ-030 Case 2, field reduction: flat_p=24'h000080, flat_q=24'h000002 -> flat_z=40'h000000001D (0x100 XOR 0x11D).
REQ-031 Case 3, accumulate: after Case 1, run again with the same operands and acc=1 -> flat_z=40'h0000000000; run once more with acc=1 -> 40'h080206030F.
REQ-032 Case 4, start ignored: during Case 1, hold start=1 with different operands through CALC and DONE -> result is unchanged at 40'h080206030F and a single done pulse occurs; a new operation is accepted only from IDLE.
REQ-033 Case 5, reset mid-op: drive rst_n=0 at CALC cycle 4 -> no done pulse, flat_z=0, busy=0; a subsequent Case 2 run completes normally.
REQ-034 Case 6, parameter sweep: NP=0/NQ=0 and NP=4/NQ=3 are checked against a reference model over at least 1000 random operand pairs, with latency checked equal to NT.
